multicycle_controller: RTL

Control FSM that sequences the team's 32-bit RV32I datapath in multicycle form: one shared instruction/data memory port, an instruction register, and a single ALU reused across cycles. It decodes the fetched instruction and steps through the states for each instruction class. It also produces the per-cycle mux selects, ALU operation and write enables. It sits beside the multicycle datapath and consumes only the opcode fields and the ALU `Zero` flag.

---
 rtl/multicycle_controller_if.sv | 33 +++
 rtl/multicycle_controller.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/multicycle_controller_if.sv
// Signal bundle between the multicycle RV32I controller and its datapath.
// The master side is the controller, which drives all control selects and enables.
interface multicycle_controller_if;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;

  logic       PCWrite;
  logic       AdrSrc;
  logic       MemWrite;
  logic       IRWrite;
  logic [1:0] ResultSrc;
  logic [1:0] ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ImmSrc;
  logic [2:0] ALUControl;
  logic       RegWrite;
  logic       Illegal;
  logic [3:0] State;

  modport master (
    input  op, funct3, funct7b5, Zero,
    output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, RegWrite, Illegal, State
  );

  modport slave (
    output op, funct3, funct7b5, Zero,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
           ImmSrc, ALUControl, RegWrite, Illegal, State
  );
endinterface

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multicycle RV32I datapath: sequences fetch, decode
// and per-class execute states, and decodes ALU operation and immediate format.
module multicycle_controller (
  input logic                    clk,
  input logic                    reset,
  multicycle_controller_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_JAL      = 4'd9,
    S_BEQ      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'd0,
    ALUOP_SUB   = 2'd1,
    ALUOP_FUNCT = 2'd2
  } aluop_t;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  state_t     state, state_next;
  aluop_t     alu_op;
  logic       pc_update, branch, ir_write, mem_write, reg_write;
  logic       adr_src, illegal;
  logic [1:0] result_src, src_a, src_b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next = S_TRAP;
    pc_update  = 1'b0;
    branch     = 1'b0;
    ir_write   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    adr_src    = 1'b0;
    illegal    = 1'b0;
    result_src = 2'b00;
    src_a      = 2'b00;
    src_b      = 2'b00;
    alu_op     = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        ir_write   = 1'b1;
        src_b      = 2'b10;
        result_src = 2'b10;
        pc_update  = 1'b1;
        state_next = S_DECODE;
      end
      S_DECODE: begin
        src_a = 2'b01;
        src_b = 2'b01;
        case (bus.op)
          OP_LW, OP_SW: state_next = S_MEMADR;
          OP_RTYPE:     state_next = S_EXECR;
          OP_ITYPE:     state_next = S_EXECI;
          OP_JAL:       state_next = S_JAL;
          OP_BEQ:       state_next = S_BEQ;
          default:      state_next = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        src_a      = 2'b10;
        src_b      = 2'b01;
        // Only lw/sw reach here; op[5] separates store from load.
        state_next = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        adr_src    = 1'b1;
        state_next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_EXECR: begin
        src_a      = 2'b10;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_write  = 1'b1;
        state_next = S_FETCH;
      end
      S_EXECI: begin
        src_a      = 2'b10;
        src_b      = 2'b01;
        alu_op     = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_JAL: begin
        src_a      = 2'b01;
        src_b      = 2'b10;
        pc_update  = 1'b1;
        state_next = S_ALUWB;
      end
      S_BEQ: begin
        src_a      = 2'b10;
        alu_op     = ALUOP_SUB;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
      S_TRAP: begin
        illegal    = 1'b1;
        state_next = S_TRAP;
      end
      default: state_next = S_TRAP;
    endcase
  end

  always_comb begin
    bus.ALUControl = 3'b000;
    case (alu_op)
      ALUOP_SUB: bus.ALUControl = 3'b001;
      ALUOP_FUNCT: begin
        case (bus.funct3)
          3'b000:  bus.ALUControl = (bus.op[5] && bus.funct7b5) ? 3'b001 : 3'b000;
          3'b010:  bus.ALUControl = 3'b101;
          3'b110:  bus.ALUControl = 3'b011;
          3'b111:  bus.ALUControl = 3'b010;
          default: bus.ALUControl = 3'b000;
        endcase
      end
      default: bus.ALUControl = 3'b000;
    endcase
  end

  always_comb begin
    case (bus.op)
      OP_SW:   bus.ImmSrc = 2'b01;
      OP_BEQ:  bus.ImmSrc = 2'b10;
      OP_JAL:  bus.ImmSrc = 2'b11;
      default: bus.ImmSrc = 2'b00;
    endcase
  end

  // Enables are gated by reset so nothing writes while reset is held low.
  always_comb begin
    bus.PCWrite   = reset & (pc_update | (branch & bus.Zero));
    bus.IRWrite   = reset & ir_write;
    bus.MemWrite  = reset & mem_write;
    bus.RegWrite  = reset & reg_write;
    bus.AdrSrc    = adr_src;
    bus.ResultSrc = result_src;
    bus.ALUSrcA   = src_a;
    bus.ALUSrcB   = src_b;
    bus.Illegal   = illegal;
    bus.State     = state;
  end

endmodule
